// File: rtl/csa_mult_pkg.sv
// Shared types and sizing helpers for the iterative carry-save multiplier.
// Optional feature macro used by the top level: SKIP_ZERO_EN.
package csa_mult_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REDUCE  = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

    // A count register must exist even for a degenerate 1-bit operand.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/csa_row.sv
// Purpose: one PROD_W-wide 3:2 carry-save compressor row.
// Latency: purely combinational. Backpressure: none, no storage.
module csa_row #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    output logic [W-1:0] s,
    output logic [W-1:0] c
);

    assign s = x ^ y ^ z;
    // The majority carry leaving the top bit is dropped; the product never needs it.
    assign c = ((x & y) | (x & z) | (y & z)) << 1;

endmodule

// File: rtl/csa_mult_sequencer.sv
// Purpose: unsigned multiplier reusing one carry-save row per partial product (macro SKIP_ZERO_EN).
// Latency: accept + WIDTH reduce cycles + 1 resolve; early exit on exhausted multiplier with SKIP_ZERO_EN.
// Backpressure: accepts only in IDLE; holds the product in DONE until out_ready.
module csa_mult_sequencer
    import csa_mult_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    localparam int PROD_W = prod_width(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_a,
    input  logic [WIDTH-1:0]  in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_p,
    output logic              busy
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t              state;
    state_t              state_nxt;
    logic [PROD_W-1:0]   a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [PROD_W-1:0]   s_reg;
    logic [PROD_W-1:0]   c_reg;
    logic [CNT_W-1:0]    count;
    logic [PROD_W-1:0]   pp;
    logic [PROD_W-1:0]   row_s;
    logic [PROD_W-1:0]   row_c;
    logic                last_step;

    assign pp = b_reg[0] ? (a_reg << count) : '0;

    csa_row #(.W(PROD_W)) u_row (
        .x (s_reg),
        .y (c_reg),
        .z (pp),
        .s (row_s),
        .c (row_c)
    );

`ifdef SKIP_ZERO_EN
    // Stop once no set multiplier bits remain beyond the one consumed this cycle.
    assign last_step = (count == CNT_W'(WIDTH - 1)) || ((b_reg >> 1) == '0);
`else
    assign last_step = (count == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = REDUCE;
            end
            REDUCE:  if (last_step) state_nxt = RESOLVE;
            RESOLVE: state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            s_reg     <= '0;
            c_reg     <= '0;
            count     <= '0;
            out_p     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= {{(PROD_W - WIDTH){1'b0}}, in_a};
                        b_reg <= in_b;
                        s_reg <= '0;
                        c_reg <= '0;
                        count <= '0;
                    end
                end
                REDUCE: begin
                    s_reg <= row_s;
                    c_reg <= row_c;
                    b_reg <= b_reg >> 1;
                    count <= count + 1'b1;
                end
                RESOLVE: begin
                    out_p     <= s_reg + c_reg;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Directed and randomised checks of csa_mult_sequencer products, latency and handshakes.
module tb_csa_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_p;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    csa_mult_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Edges from the accept edge until out_valid is visible.
    function automatic int exp_lat(input logic [31:0] b);
`ifdef SKIP_ZERO_EN
        int n;
        n = 1;
        for (int i = 0; i < 32; i++) if (b[i]) n = i + 1;
        return n + 1;
`else
        return 33;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall, input bit noise);
        int          cyc;
        logic [63:0] exp_p;
        exp_p = {32'd0, a} * {32'd0, b};
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check("in_ready_idle", in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        check("busy_after_accept", busy, 1);
        if (noise) begin
            in_a = ~a;
            in_b = ~b;
        end else begin
            in_valid = 1'b0;
        end
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("latency", cyc, exp_lat(b));
        check("product", out_p, exp_p);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_valid", out_valid, 1);
            check("stall_p", out_p, exp_p);
            check("stall_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("in_ready_after", in_ready, 1);
        check("busy_after", busy, 0);
        check("p_retained", out_p, exp_p);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          seen_valid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);

        run_op(32'd3, 32'd5, 0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        check("max_const", out_p, 64'hFFFF_FFFE_0000_0001);
        run_op(32'h1234, 32'd0, 0, 1'b0);
        run_op(32'd0, 32'hDEAD_BEEF, 1, 1'b0);
        run_op(32'hABCD, 32'd1, 0, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 2, 1'b0);
        run_op(32'h0001_0001, 32'h0000_FFFF, 10, 1'b1);

        // Abort mid-reduction: out_p is nonzero from the previous product.
        in_a     = 32'h1234_5678;
        in_b     = 32'h8000_0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_p", out_p, 0);
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_valid", seen_valid, 0);
        run_op(32'd7, 32'd9, 0, 1'b0);
        check("after_abort_63", out_p, 64'd63);

        for (int k = 0; k < 200; k++) begin
            ra = $urandom >> $urandom_range(0, 31);
            rb = $urandom >> $urandom_range(0, 31);
            run_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
